// File: rtl/awgn_pkg.sv
// Shared constants and elaboration-time helpers for the AWGN datapath.
package awgn_pkg;

  localparam int LZD_WIDTH_DEFAULT = 32;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int pow2_ceil(input int n);
    return 1 << clog2(n);
  endfunction

endpackage

// File: rtl/lzd_tree.sv
// Combinational leading-zero detector built recursively from 2-bit leaf cells.
// cnt is the full count (WIDTH when ip is all zeros); v is set when any bit of ip is 1.
module lzd_tree
  import awgn_pkg::*;
#(
  parameter int WIDTH = LZD_WIDTH_DEFAULT,
  localparam int CNT_W = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] ip,
  output logic [CNT_W-1:0] cnt,
  output logic             v
);

  localparam int P = pow2_ceil(WIDTH);

  generate
    if (P != WIDTH) begin : g_pad
      // Pad the LSB side with ones: the padded tree always finds a 1, so its count
      // never exceeds WIDTH and the padding never contributes to it.
      localparam int CPW = clog2(P + 1);
      logic [P-1:0]   ip_pad;
      logic [CPW-1:0] cnt_pad;
      logic           v_pad;
      logic           unused_pad;

      assign ip_pad = {ip, {(P - WIDTH){1'b1}}};

      lzd_tree #(.WIDTH(P)) u_pad (
        .ip  (ip_pad),
        .cnt (cnt_pad),
        .v   (v_pad)
      );

      assign cnt        = cnt_pad[CNT_W-1:0];
      assign v          = (cnt_pad[CNT_W-1:0] != CNT_W'(WIDTH));
      assign unused_pad = ^{v_pad, cnt_pad[CPW-1:CNT_W]};
    end else if (WIDTH == 2) begin : g_leaf
      assign v   = ip[0] | ip[1];
      assign cnt = v ? {1'b0, ip[0] & ~ip[1]} : 2'd2;
    end else begin : g_node
      localparam int H  = WIDTH / 2;
      localparam int HC = clog2(H + 1);
      logic [HC-1:0] cnt_hi;
      logic [HC-1:0] cnt_lo;
      logic          v_hi;
      logic          v_lo;

      lzd_tree #(.WIDTH(H)) u_hi (
        .ip  (ip[WIDTH-1:H]),
        .cnt (cnt_hi),
        .v   (v_hi)
      );

      lzd_tree #(.WIDTH(H)) u_lo (
        .ip  (ip[H-1:0]),
        .cnt (cnt_lo),
        .v   (v_lo)
      );

      // Lower half selected: prefix a 1 to its count; an all-zero lower half (count H)
      // rolls over to exactly WIDTH.
      assign v   = v_hi | v_lo;
      assign cnt = v_hi ? {1'b0, cnt_hi}
                        : {cnt_lo[HC-1], ~cnt_lo[HC-1], cnt_lo[HC-2:0]};
    end
  endgenerate

endmodule

// File: rtl/lzd_norm_pipe.sv
// Two-stage leading-zero count and normalise pipeline with valid/ready backpressure.
// S1 holds the word plus its count; S2 holds the shifted word and drives the outputs.
module lzd_norm_pipe
  import awgn_pkg::*;
#(
  parameter int WIDTH = LZD_WIDTH_DEFAULT,
  parameter int TAG_W = 4,
  localparam int CNT_W = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_lz,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAG_W-1:0] out_tag
);

  logic [CNT_W-1:0] lz_cnt;
  logic             lz_v;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  logic [CNT_W-1:0] s1_lz_q,    s1_lz_d;
  logic             s1_zero_q,  s1_zero_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_norm_q,  s2_norm_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
  logic [CNT_W-1:0] s2_lz_q,    s2_lz_d;
  logic             s2_zero_q,  s2_zero_d;

  logic             s1_adv;
  logic             s2_adv;

  lzd_tree #(.WIDTH(WIDTH)) u_lzd (
    .ip  (in_data),
    .cnt (lz_cnt),
    .v   (lz_v)
  );

  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_tag_d   = s1_tag_q;
    s1_lz_d    = s1_lz_q;
    s1_zero_d  = s1_zero_q;
    s2_valid_d = s2_valid_q;
    s2_norm_d  = s2_norm_q;
    s2_tag_d   = s2_tag_q;
    s2_lz_d    = s2_lz_q;
    s2_zero_d  = s2_zero_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_tag_d  = in_tag;
        s1_lz_d   = lz_cnt;
        s1_zero_d = !lz_v;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        // A count of WIDTH shifts everything out, giving the all-zero result.
        s2_norm_d = s1_data_q << s1_lz_q;
        s2_tag_d  = s1_tag_q;
        s2_lz_d   = s1_lz_q;
        s2_zero_d = s1_zero_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      s1_lz_q    <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_norm_q  <= '0;
      s2_tag_q   <= '0;
      s2_lz_q    <= '0;
      s2_zero_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_tag_q   <= s1_tag_d;
      s1_lz_q    <= s1_lz_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_norm_q  <= s2_norm_d;
      s2_tag_q   <= s2_tag_d;
      s2_lz_q    <= s2_lz_d;
      s2_zero_q  <= s2_zero_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_lz    = s2_lz_q;
  assign out_zero  = s2_zero_q;
  assign out_norm  = s2_norm_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// Bench for lzd_norm_pipe at WIDTH=16 (scoreboarded) and WIDTH=12 (directed).
module tb_lzd_norm_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [15:0] in_data, out_norm;
  logic [3:0]  in_tag, out_tag;
  logic [4:0]  out_lz;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
  logic [11:0] b_in_data, b_out_norm;
  logic [3:0]  b_in_tag, b_out_tag, b_out_lz;

  lzd_norm_pipe #(.WIDTH(16), .TAG_W(4)) u_dut16 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data), .in_tag (in_tag),
    .out_valid (out_valid), .out_ready (out_ready), .out_lz (out_lz),
    .out_zero (out_zero), .out_norm (out_norm), .out_tag (out_tag)
  );

  lzd_norm_pipe #(.WIDTH(12), .TAG_W(4)) u_dut12 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data), .in_tag (b_in_tag),
    .out_valid (b_out_valid), .out_ready (b_out_ready), .out_lz (b_out_lz),
    .out_zero (b_out_zero), .out_norm (b_out_norm), .out_tag (b_out_tag)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          lz;
    logic        zero;
    logic [31:0] norm;
    logic [3:0]  tag;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] out_log[$];

  // Reference: scan for the highest set bit, then shift arithmetically.
  function automatic exp_t model(input int w, input logic [31:0] x, input logic [3:0] tag);
    exp_t e;
    e.lz = w;
    for (int i = 0; i < w; i++) if (x[i]) e.lz = w - 1 - i;
    e.zero = (e.lz == w);
    e.norm = (x << e.lz) & ((32'h1 << w) - 32'h1);
    e.tag  = tag;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process for the 16-bit instance.
  logic        stall_p = 1'b0;
  logic [4:0]  h_lz;
  logic        h_zero;
  logic [15:0] h_norm;
  logic [3:0]  h_tag;
  exp_t        e_mon;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      stall_p = 1'b0;
      check("rst_out_valid", out_valid, 0);
    end else begin
      if (stall_p) begin
        check("stall_lz",   out_lz,   h_lz);
        check("stall_zero", out_zero, h_zero);
        check("stall_norm", out_norm, h_norm);
        check("stall_tag",  out_tag,  h_tag);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected_out: actual tag=%0h required=no output", out_tag);
        end else begin
          e_mon = sb_q.pop_front();
          check("sb_lz",   out_lz,   e_mon.lz);
          check("sb_zero", out_zero, e_mon.zero);
          check("sb_norm", out_norm, e_mon.norm);
          check("sb_tag",  out_tag,  e_mon.tag);
          out_log.push_back(out_tag);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(16, {16'h0, in_data}, in_tag));
      stall_p = out_valid && !out_ready;
      h_lz    = out_lz;
      h_zero  = out_zero;
      h_norm  = out_norm;
      h_tag   = out_tag;
    end
  end

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while ((sb_q.size() != 0 || out_valid) && i < budget) begin
      tick();
      i++;
    end
    if (i == budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: actual pending=%0d required=0", sb_q.size());
    end
  endtask

  initial begin
    exp_t        e;
    int          k;
    int          sent;
    int          base;
    int          sh;
    logic [31:0] r;

    in_valid = 0; in_data = '0; in_tag = '0; out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_tag = '0; b_out_ready = 1;

    e = model(16, 32'h0F00, 4'd0);
    check("model_pin_lz16", e.lz, 4);
    check("model_pin_norm16", e.norm, 32'hF000);
    e = model(12, 32'h000, 4'd0);
    check("model_pin_lz12", e.lz, 12);
    check("model_pin_zero12", e.zero, 1);

    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_lz", out_lz, 0);
    check("rst_zero", out_zero, 0);
    check("rst_norm", out_norm, 0);
    check("rst_tag", out_tag, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    #2 rst_n = 1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Single word, latency two cycles.
    in_valid = 1; in_data = 16'h0001; in_tag = 4'd3;
    tick();
    in_valid = 0;
    @(negedge clk);
    check("lat_not_early", out_valid, 0);
    tick();
    @(negedge clk);
    check("t1_valid", out_valid, 1);
    check("t1_lz", out_lz, 15);
    check("t1_norm", out_norm, 16'h8000);
    check("t1_zero", out_zero, 0);
    check("t1_tag", out_tag, 3);

    // Back-to-back words.
    tick();
    in_valid = 1; in_data = 16'h0000; in_tag = 4'd1;
    tick();
    in_data = 16'h8000; in_tag = 4'd2;
    tick();
    in_data = 16'h0F00; in_tag = 4'd4;
    @(negedge clk);
    check("b2b0_valid", out_valid, 1);
    check("b2b0_lz", out_lz, 16);
    check("b2b0_zero", out_zero, 1);
    check("b2b0_norm", out_norm, 0);
    tick();
    in_valid = 0;
    @(negedge clk);
    check("b2b1_valid", out_valid, 1);
    check("b2b1_lz", out_lz, 0);
    check("b2b1_norm", out_norm, 16'h8000);
    tick();
    @(negedge clk);
    check("b2b2_valid", out_valid, 1);
    check("b2b2_lz", out_lz, 4);
    check("b2b2_norm", out_norm, 16'hF000);

    // Backpressure: 4 stalled cycles while streaming tags 0..5.
    tick();
    base = out_log.size();
    k = 0;
    for (int cyc = 0; cyc < 100 && k < 6; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = 1;
      in_data   = 16'h8000 >> (k * 2);
      in_tag    = 4'(k);
      @(negedge clk);
      if (cyc == 3) begin
        check("bp_accepts", k, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_out_tag", out_tag, 0);
      end
      if (in_ready) k++;
      tick();
    end
    in_valid  = 0;
    out_ready = 1;
    wait_drain(50);
    check("bp_count", out_log.size() - base, 6);
    for (int i = 0; i < 6 && base + i < out_log.size(); i++)
      check("bp_order", out_log[base + i], i);

    // Random stream with random backpressure.
    base = out_log.size();
    sent = 0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = ($urandom_range(0, 3) != 0);
      r         = $urandom;
      sh        = $urandom_range(0, 17);
      in_data   = (sh >= 16) ? 16'h0 : (r[15:0] >> sh);
      in_tag    = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 0;
    out_ready = 1;
    wait_drain(50);
    check("rnd_sent", sent, 10000);
    check("rnd_out_count", out_log.size() - base, 10000);

    // Reset with both stages full.
    out_ready = 0;
    in_valid = 1; in_data = 16'h1234; in_tag = 4'd7;
    tick();
    in_data = 16'h0042; in_tag = 4'd8;
    tick();
    in_valid = 0;
    check("pre_rst_full", out_valid, 1);
    #2 rst_n = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_lz", out_lz, 0);
    @(negedge clk);
    #2 rst_n = 1;
    out_ready = 1;
    tick();
    check("rel_in_ready", in_ready, 1);
    in_valid = 1; in_data = 16'h0010; in_tag = 4'd9;
    tick();
    in_valid = 0;
    @(negedge clk);
    check("rel_no_stale", out_valid, 0);
    tick();
    @(negedge clk);
    check("rel_valid", out_valid, 1);
    check("rel_lz", out_lz, 11);
    check("rel_norm", out_norm, 16'h8000);
    check("rel_tag", out_tag, 9);

    // WIDTH=12 instance.
    tick();
    b_in_valid = 1; b_in_data = 12'h001; b_in_tag = 4'd1;
    tick();
    b_in_data = 12'h800; b_in_tag = 4'd2;
    tick();
    b_in_data = 12'h000; b_in_tag = 4'd3;
    @(negedge clk);
    check("w12_0_valid", b_out_valid, 1);
    check("w12_0_lz", b_out_lz, 11);
    check("w12_0_norm", b_out_norm, 12'h800);
    check("w12_0_zero", b_out_zero, 0);
    tick();
    b_in_valid = 0;
    @(negedge clk);
    check("w12_1_lz", b_out_lz, 0);
    check("w12_1_norm", b_out_norm, 12'h800);
    check("w12_1_tag", b_out_tag, 2);
    tick();
    @(negedge clk);
    check("w12_2_valid", b_out_valid, 1);
    check("w12_2_lz", b_out_lz, 12);
    check("w12_2_zero", b_out_zero, 1);
    check("w12_2_norm", b_out_norm, 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lzd_norm_pipe.md
Name: lzd_norm_pipe

Overview:
- Parametrised, pipelined leading-zero detector and normaliser for the AWGN datapath.
- For each input word it produces:
  - the leading-zero count;
  - an all-zero flag;
  - the word left-shifted so that its MSB is 1.
- Feeds the log/sqrt range-reduction stages of the Box-Muller core.
- Uses a valid/ready handshake with full backpressure, and carries a sideband tag alongside each word.

Parameters:
- WIDTH, 32, data width in bits; any value >= 2 (need not be a power of two).
- TAG_W, 4, sideband tag width in bits; must be >= 1.
- CNT_W, $clog2(WIDTH+1), count width; derived, never overridden.

Ports:
- clk  in  1  single clock; all registers on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  word to examine.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_lz  out  CNT_W  leading-zero count, 0..WIDTH.
- out_zero  out  1  1 when in_data was all zeros.
- out_norm  out  WIDTH  in_data << out_lz; all zeros when out_zero.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset: asserting rst_n low clears both stage valid bits immediately, with no clock required.
  - out_valid = 0; out_lz, out_zero, out_norm and out_tag reset to 0.
  - in_ready = 1 from the first cycle after rst_n deasserts.
- Reset mid-operation discards all in-flight words; nothing is emitted for them.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stage 1 (S1): registers in_data and in_tag, plus the leading-zero count and zero flag from an lzd_tree.
- Stage 2 (S2): registers the barrel-shifted word (S1 data << S1 count), the count, the flag and the tag. S2 registers drive the outputs directly.
- Latency: a word accepted in cycle N appears with out_valid=1 in cycle N+2 when there is no backpressure.
- Throughput: 1 word/cycle.
- Stage advance:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is a combinational path from out_ready and is permitted.
- Stalling: when a stage does not advance, it holds its contents and valid bit. Data, lz, zero and tag never change while out_valid=1 && !out_ready.
- Capacity: 2 words. Order is strictly preserved; no word is dropped or duplicated.
- Simultaneous in/out transfer with both stages full: the pipeline shifts by one and stays full.
- Count rule:
  - out_lz = number of consecutive zeros from in_data[WIDTH-1] downward.
  - All-zero input gives out_lz = WIDTH and out_zero = 1.
- Non-power-of-two WIDTH: the tree pads the LSB side with ones up to the next power of two, so padding never adds to the count.
- Tree construction:
  - Leaves are 2-bit cells: p = ip[0] & ~ip[1], v = ip[0] | ip[1].
  - Each merge level takes the upper half's result if its v=1; otherwise it takes the lower half's result with a 1 prefixed to the count.
  - v = v_hi | v_lo.
- The shift is logical left with zero fill. out_norm[WIDTH-1] = 1 whenever out_zero = 0.
- Data registers may be left without reset; only the valid bits require reset. The reset values above are still required at the ports, so zero the output registers too.

Decomposition:
- Shared package awgn_pkg:
  - a clog2 function;
  - the default LZD width constant;
  - a helper that rounds a width up to the next power of two.
- Sub-module lzd_tree (parameter WIDTH; outputs cnt[CNT_W-1:0] and v): purely combinational and recursive/generate-built from the 2-bit leaf cells.
- lzd_norm_pipe owns the pipeline, the handshake and the barrel shifter.

Test Plan:
- WIDTH=16, out_ready=1, send 16'h0001 with tag 3 -> two cycles later out_lz=15, out_norm=16'h8000, out_zero=0, out_tag=3.
- Send 16'h0000, then 16'h8000, then 16'h0F00 back-to-back -> consecutive cycles give:
  - lz=16, zero=1, norm=0;
  - lz=0, norm=16'h8000;
  - lz=4, norm=16'hF000.
- Backpressure: stream tags 0..5 with out_ready=0 for 4 cycles, then out_ready=1 -> in_ready drops after 2 accepts, outputs hold stable while stalled, then tags 0..5 emerge in order with none lost.
- Random out_ready toggling over 10k random words, with a scoreboard reference model -> every result matches the model and no gaps or duplicates occur.
- Reset mid-stream: assert rst_n low with both stages full -> out_valid=0 immediately. After release, in_ready=1 and the next word 16'h0010 yields lz=11 with no stale output.
- WIDTH=12: inputs 12'h001, 12'h800 and 12'h000 -> lz=11, 0 and 12 respectively; norm=12'h800 for the first two and 0 for the last.
